// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bus between the requesters and the shared-MUX arbiter.
// The master side drives req/done; the arbiter (slave) returns grant/select/valid.
interface mux_sel_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int SEL_WIDTH = 2
);
  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     done;
  logic [N_REQ-1:0]     grant;
  logic [SEL_WIDTH-1:0] select;
  logic                 valid;

  modport master (
    output req,
    output done,
    input  grant,
    input  select,
    input  valid
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output select,
    output valid
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner arbiter for a shared N-input MUX: one-hot grant, MUX select
// index and bounded tenure (MAX_HOLD), with back-to-back handover and no idle bubble.
module mux_sel_arbiter #(
  parameter int N_REQ     = 4,
  parameter int SEL_WIDTH = 2,
  parameter int MAX_HOLD  = 4
) (
  input  logic             clk,
  input  logic             reset,
  mux_sel_arbiter_if.slave bus
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD) : HOLD_W'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  state_e               state_q;
  logic [N_REQ-1:0]     grant_q;
  logic [SEL_WIDTH-1:0] select_q;
  logic                 valid_q;
  logic [SEL_WIDTH-1:0] last_q;
  logic [HOLD_W-1:0]    hold_q;
  logic [HOLD_W-1:0]    hold_d;

  logic [N_REQ-1:0]     elig_s;
  logic                 own_req_s;
  logic                 own_done_s;
  logic                 timeout_s;
  logic                 release_s;
  logic                 any_elig_s;
  logic [SEL_WIDTH-1:0] base_s;
  logic [SEL_WIDTH-1:0] idx_s;
  logic [SEL_WIDTH-1:0] winner_s;
  logic [N_REQ-1:0]     winner_oh_s;

  // Release detection and round-robin winner search over the eligible requests.
  always_comb begin
    // grant_q is zero in IDLE, so this is plain req there and req minus the owner otherwise
    elig_s      = bus.req & ~grant_q;
    own_req_s   = |(bus.req & grant_q);
    own_done_s  = |(bus.done & grant_q);
    timeout_s   = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && (|elig_s);
    release_s   = (state_q == ST_OWN) && (!own_req_s || own_done_s || timeout_s);
    any_elig_s  = |elig_s;
    base_s      = (state_q == ST_OWN) ? select_q : last_q;
    hold_d      = (hold_q < HOLD_MAX) ? (hold_q + HOLD_W'(1)) : hold_q;
    idx_s       = '0;
    winner_s    = '0;
    // Scan from farthest to nearest so the nearest eligible index after base wins.
    for (int i = N_REQ; i >= 1; i--) begin
      idx_s    = SEL_WIDTH'((int'(base_s) + i) % N_REQ);
      winner_s = elig_s[idx_s] ? idx_s : winner_s;
    end
    winner_oh_s = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
  end

  // Ownership FSM with registered grant/select/valid and tenure counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      select_q <= '0;
      valid_q  <= 1'b0;
      hold_q   <= '0;
      last_q   <= SEL_WIDTH'(N_REQ - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_elig_s) begin
            state_q  <= ST_OWN;
            grant_q  <= winner_oh_s;
            select_q <= winner_s;
            valid_q  <= 1'b1;
            hold_q   <= HOLD_W'(1);
          end
        end
        ST_OWN: begin
          if (release_s) begin
            last_q <= select_q;
            if (any_elig_s) begin
              grant_q  <= winner_oh_s;
              select_q <= winner_s;
              valid_q  <= 1'b1;
              hold_q   <= HOLD_W'(1);
            end else begin
              state_q  <= ST_IDLE;
              grant_q  <= '0;
              select_q <= '0;
              valid_q  <= 1'b0;
              hold_q   <= '0;
            end
          end else begin
            hold_q <= hold_d;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          grant_q  <= '0;
          select_q <= '0;
          valid_q  <= 1'b0;
          hold_q   <= '0;
        end
      endcase
    end
  end

  assign bus.grant  = grant_q;
  assign bus.select = select_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed vector table, hand-written timeout/sole-owner
// sequences, then random traffic against a behavioural round-robin model.
module tb_mux_sel_arbiter;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mux_sel_arbiter_if #(.N_REQ(N), .SEL_WIDTH(SW)) bus ();

  mux_sel_arbiter #(.N_REQ(N), .SEL_WIDTH(SW), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: owner index (-1 = idle), last served index, tenure length.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_hold  = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
  } vec_t;

  vec_t tbl[21];

  function automatic int rr_pick(input logic [N-1:0] mask, input int from);
    for (int i = 1; i <= N; i++) begin
      if (mask[(from + i) % N]) return (from + i) % N;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic rst, input logic [N-1:0] req, input logic [N-1:0] done);
    logic [N-1:0] others;
    bit rel;
    if (rst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      if (req != 0) begin
        m_owner = rr_pick(req, m_last);
        m_hold  = 1;
      end
    end else begin
      others = req & ~(N'(1) << m_owner);
      rel = !req[m_owner] || done[m_owner] || (MH != 0 && m_hold == MH && others != 0);
      if (rel) begin
        m_last = m_owner;
        if (others != 0) begin
          m_owner = rr_pick(others, m_last);
          m_hold  = 1;
        end else begin
          m_owner = -1;
          m_hold  = 0;
        end
      end else if (m_hold < MH) begin
        m_hold = m_hold + 1;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s, input logic v);
    chk({tag, ".grant"},  32'(bus.grant),  32'(g));
    chk({tag, ".select"}, 32'(bus.select), 32'(s));
    chk({tag, ".valid"},  32'(bus.valid),  32'(v));
  endtask

  task automatic cycle(input logic rst, input logic [N-1:0] req, input logic [N-1:0] done);
    reset    = rst;
    bus.req  = req;
    bus.done = done;
    @(posedge clk);
    model_step(rst, req, done);
    #1;
  endtask

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] dn;
    logic         rs;
    logic [3:0]   eg;
    logic [1:0]   es;

    //           rst   req    done   grant  sel    valid
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 4'hF, 4'h0, 4'h1, 2'd0, 1'b1};
    tbl[4]  = '{1'b0, 4'hF, 4'h1, 4'h2, 2'd1, 1'b1};
    tbl[5]  = '{1'b0, 4'hF, 4'h2, 4'h4, 2'd2, 1'b1};
    tbl[6]  = '{1'b0, 4'hF, 4'h4, 4'h8, 2'd3, 1'b1};
    tbl[7]  = '{1'b0, 4'hF, 4'h8, 4'h1, 2'd0, 1'b1};
    tbl[8]  = '{1'b0, 4'hF, 4'h1, 4'h2, 2'd1, 1'b1};
    tbl[9]  = '{1'b0, 4'h2, 4'h0, 4'h2, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 4'h8, 4'h0, 4'h8, 2'd3, 1'b1};
    tbl[11] = '{1'b0, 4'h4, 4'h0, 4'h4, 2'd2, 1'b1};
    tbl[12] = '{1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[13] = '{1'b0, 4'hF, 4'h0, 4'h1, 2'd0, 1'b1};
    tbl[14] = '{1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[15] = '{1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0};
    tbl[16] = '{1'b0, 4'h9, 4'h0, 4'h8, 2'd3, 1'b1};
    tbl[17] = '{1'b0, 4'h9, 4'h1, 4'h8, 2'd3, 1'b1};
    tbl[18] = '{1'b0, 4'h9, 4'h0, 4'h8, 2'd3, 1'b1};
    tbl[19] = '{1'b0, 4'h9, 4'h0, 4'h8, 2'd3, 1'b1};
    tbl[20] = '{1'b0, 4'h9, 4'h8, 4'h1, 2'd0, 1'b1};

    for (int i = 0; i < 21; i++) begin
      cycle(tbl[i].rst, tbl[i].req, tbl[i].done);
      chk_out($sformatf("tbl%0d", i), tbl[i].grant, tbl[i].sel, tbl[i].valid);
    end

    // Two requesters, no done: tenure bounded to MH cycles, alternating owners.
    cycle(1'b1, 4'h0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 4'b0011, 4'h0);
      es = 2'((i / MH) % 2);
      eg = 4'(1) << es;
      chk_out($sformatf("timeout%0d", i), eg, es, 1'b1);
    end

    // Sole requester keeps the grant indefinitely.
    cycle(1'b1, 4'h0, 4'h0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 4'b0100, 4'h0);
      chk_out($sformatf("sole%0d", i), 4'b0100, 2'd2, 1'b1);
    end

    // Random traffic against the model.
    cycle(1'b1, 4'h0, 4'h0);
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      end
      dn = '0;
      if ($urandom_range(0, 3) == 0) begin
        if (m_owner >= 0 && $urandom_range(0, 1) == 0) dn = N'(1) << m_owner;
        else dn = N'(1) << $urandom_range(0, N - 1);
      end
      rs = ($urandom_range(0, 199) == 0);
      cycle(rs, rq, dn);
      eg = (m_owner < 0) ? 4'h0 : (4'(1) << m_owner);
      es = (m_owner < 0) ? 2'd0 : 2'(m_owner);
      chk_out($sformatf("rand%0d", i), eg, es, (m_owner >= 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
